// File: rtl/hazard_scoreboard.sv
// Per-register RAW/WAW hazard scoreboard between decode and execute.
// Define HAZARD_SB_FWD_EN to let operands whose fixed producer finishes this cycle issue via the bypass.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 4,
  parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [REG_ADDR_W-1:0]        issue_rs1_i,
  input  logic [REG_ADDR_W-1:0]        issue_rs2_i,
  input  logic                         issue_rs1_rd_i,
  input  logic                         issue_rs2_rd_i,
  input  logic [REG_ADDR_W-1:0]        issue_rd_i,
  input  logic                         issue_we_i,
  input  logic [LAT_W-1:0]             issue_lat_i,
  input  logic                         issue_var_i,
  input  logic                         cmpl_valid_i,
  input  logic [REG_ADDR_W-1:0]        cmpl_rd_i,
  input  logic                         flush_i,
  output logic [(1<<REG_ADDR_W)-1:0]   busy_o,
  output logic                         raw_stall_o,
  output logic                         waw_stall_o,
  output logic                         fwd_rs1_o,
  output logic                         fwd_rs2_o,
  output logic                         cmpl_err_o
);
  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [NUM_REGS-1:0]            pend_q, pend_d;
  logic [NUM_REGS-1:0]            var_q, var_d;
  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic                           cmpl_err_q, cmpl_err_d;

  logic [LAT_W-1:0] eff_lat;
  logic             src1_pend, src2_pend;
  logic             fwd_ok1, fwd_ok2;
  logic             raw, waw, accept, wr_en;

  // Latency 0 behaves as 1; anything above MAX_LAT saturates.
  always_comb begin
    eff_lat = issue_lat_i;
    if (issue_lat_i == '0) begin
      eff_lat = LAT_W'(1);
    end else if (issue_lat_i > LAT_W'(MAX_LAT)) begin
      eff_lat = LAT_W'(MAX_LAT);
    end
  end

  always_comb begin
    src1_pend = issue_rs1_rd_i && (issue_rs1_i != '0) && pend_q[issue_rs1_i];
    src2_pend = issue_rs2_rd_i && (issue_rs2_i != '0) && pend_q[issue_rs2_i];
`ifdef HAZARD_SB_FWD_EN
    fwd_ok1 = !var_q[issue_rs1_i] && (cnt_q[issue_rs1_i] == LAT_W'(1));
    fwd_ok2 = !var_q[issue_rs2_i] && (cnt_q[issue_rs2_i] == LAT_W'(1));
`else
    fwd_ok1 = 1'b0;
    fwd_ok2 = 1'b0;
`endif
    fwd_rs1_o = src1_pend && fwd_ok1;
    fwd_rs2_o = src2_pend && fwd_ok2;
    raw = (src1_pend && !fwd_ok1) || (src2_pend && !fwd_ok2);
    // A younger write must never retire before an older one to the same rd.
    waw = issue_we_i && (issue_rd_i != '0) && pend_q[issue_rd_i] &&
          (var_q[issue_rd_i] || issue_var_i || (cnt_q[issue_rd_i] > eff_lat));
    issue_ready_o = !raw && !waw && !flush_i;
    raw_stall_o   = issue_valid_i && raw;
    waw_stall_o   = issue_valid_i && waw;
    accept        = issue_valid_i && issue_ready_o;
    wr_en         = accept && issue_we_i && (issue_rd_i != '0);
  end

  always_comb begin
    pend_d = pend_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (wr_en && (issue_rd_i == REG_ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
        var_d[r]  = issue_var_i;
        cnt_d[r]  = eff_lat;
      end else if (flush_i && !var_q[r]) begin
        pend_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end else if (cmpl_valid_i && (cmpl_rd_i == REG_ADDR_W'(r)) && pend_q[r] && var_q[r]) begin
        pend_d[r] = 1'b0;
        var_d[r]  = 1'b0;
        cnt_d[r]  = '0;
      end else if (pend_q[r] && !var_q[r]) begin
        if (cnt_q[r] > LAT_W'(1)) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end else begin
          pend_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end
      end
    end
    pend_d[0] = 1'b0;
    var_d[0]  = 1'b0;
    cnt_d[0]  = '0;
    cmpl_err_d = cmpl_valid_i && (cmpl_rd_i != '0) &&
                 !(pend_q[cmpl_rd_i] && var_q[cmpl_rd_i]);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pend_q     <= '0;
      var_q      <= '0;
      cnt_q      <= '0;
      cmpl_err_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      var_q      <= var_d;
      cnt_q      <= cnt_d;
      cmpl_err_q <= cmpl_err_d;
    end
  end

  assign busy_o     = pend_q;
  assign cmpl_err_o = cmpl_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// against a timestamp-based reference model (expiry cycle per register).
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_LAT    = 4;
  localparam int LAT_W      = $clog2(MAX_LAT + 1);
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
`ifdef HAZARD_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                  clk_i;
  logic                  reset_n_i;
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [REG_ADDR_W-1:0] issue_rs1_i;
  logic [REG_ADDR_W-1:0] issue_rs2_i;
  logic                  issue_rs1_rd_i;
  logic                  issue_rs2_rd_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic                  issue_we_i;
  logic [LAT_W-1:0]      issue_lat_i;
  logic                  issue_var_i;
  logic                  cmpl_valid_i;
  logic [REG_ADDR_W-1:0] cmpl_rd_i;
  logic                  flush_i;
  logic [NUM_REGS-1:0]   busy_o;
  logic                  raw_stall_o;
  logic                  waw_stall_o;
  logic                  fwd_rs1_o;
  logic                  fwd_rs2_o;
  logic                  cmpl_err_o;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .MAX_LAT(MAX_LAT)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs1_rd_i(issue_rs1_rd_i), .issue_rs2_rd_i(issue_rs2_rd_i),
    .issue_rd_i(issue_rd_i), .issue_we_i(issue_we_i),
    .issue_lat_i(issue_lat_i), .issue_var_i(issue_var_i),
    .cmpl_valid_i(cmpl_valid_i), .cmpl_rd_i(cmpl_rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .raw_stall_o(raw_stall_o), .waw_stall_o(waw_stall_o),
    .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o), .cmpl_err_o(cmpl_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: a fixed write is busy up to and including cycle expire[r];
  // a variable write is busy until its completion is seen.
  int expire [NUM_REGS];
  bit vpend  [NUM_REGS];
  int cyc;
  bit err_exp;
  int n_vec;
  int n_err;

  function automatic void model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      expire[r] = -1;
      vpend[r]  = 1'b0;
    end
    err_exp = 1'b0;
  endfunction

  function automatic int eff_lat(int l);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic bit m_busy(int r);
    return (r != 0) && (vpend[r] || (cyc <= expire[r]));
  endfunction

  function automatic bit m_fwd_ok(int r);
    return FWD && !vpend[r] && (cyc == expire[r]);
  endfunction

  function automatic bit m_fwd(bit rd_en, int r);
    return rd_en && m_busy(r) && m_fwd_ok(r);
  endfunction

  function automatic bit m_raw();
    int s1, s2;
    s1 = int'(issue_rs1_i);
    s2 = int'(issue_rs2_i);
    return (issue_rs1_rd_i && m_busy(s1) && !m_fwd_ok(s1)) ||
           (issue_rs2_rd_i && m_busy(s2) && !m_fwd_ok(s2));
  endfunction

  function automatic bit m_waw();
    int d;
    d = int'(issue_rd_i);
    return issue_we_i && m_busy(d) &&
           (vpend[d] || issue_var_i || ((expire[d] - cyc + 1) > eff_lat(int'(issue_lat_i))));
  endfunction

  function automatic bit m_ready();
    return !m_raw() && !m_waw() && !flush_i;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_busy_vec();
    logic [NUM_REGS-1:0] v;
    for (int r = 0; r < NUM_REGS; r++) v[r] = m_busy(r);
    return v;
  endfunction

  task automatic set_idle();
    issue_valid_i  = 1'b0;
    issue_rs1_i    = '0;
    issue_rs2_i    = '0;
    issue_rs1_rd_i = 1'b0;
    issue_rs2_rd_i = 1'b0;
    issue_rd_i     = '0;
    issue_we_i     = 1'b0;
    issue_lat_i    = '0;
    issue_var_i    = 1'b0;
    cmpl_valid_i   = 1'b0;
    cmpl_rd_i      = '0;
    flush_i        = 1'b0;
  endtask

  task automatic drive_write(int rd, int lat, bit is_var);
    set_idle();
    issue_valid_i = 1'b1;
    issue_we_i    = 1'b1;
    issue_rd_i    = REG_ADDR_W'(rd);
    issue_lat_i   = LAT_W'(lat);
    issue_var_i   = is_var;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit acc;
    int d;
    @(posedge clk_i);
    acc = issue_valid_i && m_ready();
    d = int'(issue_rd_i);
    err_exp = cmpl_valid_i && (cmpl_rd_i != '0) && !vpend[cmpl_rd_i];
    if (cmpl_valid_i && vpend[cmpl_rd_i]) vpend[cmpl_rd_i] = 1'b0;
    if (flush_i) for (int r = 0; r < NUM_REGS; r++) expire[r] = -1;
    if (acc && issue_we_i && d != 0) begin
      if (issue_var_i) begin
        vpend[d]  = 1'b1;
        expire[d] = -1;
      end else begin
        vpend[d]  = 1'b0;
        expire[d] = cyc + eff_lat(int'(issue_lat_i));
      end
      $display("txn cyc=%0d write x%0d lat=%0d var=%0b", cyc, d, int'(issue_lat_i), issue_var_i);
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    issue_valid_i  = 1'b1;
    issue_rs1_i    = 5'd5;
    issue_rs1_rd_i = 1'b1;
    #1;
    n_vec++; if (busy_o !== '0) begin n_err++; $display("FAIL reset_busy got %h exp 0", busy_o); end
    n_vec++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", issue_ready_o); end
    n_vec++; if ({raw_stall_o, waw_stall_o} !== 2'b00) begin n_err++; $display("FAIL reset_stall got %b%b exp 00", raw_stall_o, waw_stall_o); end
    n_vec++; if ({fwd_rs1_o, fwd_rs2_o, cmpl_err_o} !== 3'b000) begin n_err++; $display("FAIL reset_misc got %b%b%b exp 000", fwd_rs1_o, fwd_rs2_o, cmpl_err_o); end
    tick();
    set_idle();
  endtask

  task automatic test_fixed_raw();
    bit er, ef, eb;
    do_reset();
    drive_write(5, 3, 1'b0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      set_idle();
      issue_valid_i  = 1'b1;
      issue_rs1_i    = 5'd5;
      issue_rs1_rd_i = 1'b1;
      #1;
      er = (k >= 4) || (FWD && k == 3);
      ef = FWD && (k == 3);
      eb = (k <= 3);
      n_vec++; if (issue_ready_o !== er) begin n_err++; $display("FAIL fixed_raw_ready c%0d got %b exp %b", k, issue_ready_o, er); end
      n_vec++; if (raw_stall_o !== !er) begin n_err++; $display("FAIL fixed_raw_stall c%0d got %b exp %b", k, raw_stall_o, !er); end
      n_vec++; if (fwd_rs1_o !== ef) begin n_err++; $display("FAIL fixed_raw_fwd c%0d got %b exp %b", k, fwd_rs1_o, ef); end
      n_vec++; if (busy_o[5] !== eb) begin n_err++; $display("FAIL fixed_raw_busy c%0d got %b exp %b", k, busy_o[5], eb); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_var_cmpl();
    do_reset();
    drive_write(7, 1, 1'b1);
    tick();
    for (int k = 1; k <= 11; k++) begin
      set_idle();
      issue_valid_i  = 1'b1;
      issue_rs2_i    = 5'd7;
      issue_rs2_rd_i = 1'b1;
      cmpl_valid_i   = (k == 10);
      cmpl_rd_i      = 5'd7;
      #1;
      n_vec++; if (issue_ready_o !== (k >= 11)) begin n_err++; $display("FAIL var_ready c%0d got %b exp %b", k, issue_ready_o, (k >= 11)); end
      n_vec++; if (busy_o[7] !== (k <= 10)) begin n_err++; $display("FAIL var_busy c%0d got %b exp %b", k, busy_o[7], (k <= 10)); end
      n_vec++; if (fwd_rs2_o !== 1'b0) begin n_err++; $display("FAIL var_fwd c%0d got %b exp 0", k, fwd_rs2_o); end
      tick();
    end
    set_idle();
    cmpl_valid_i = 1'b1;
    cmpl_rd_i    = 5'd8;
    #1;
    n_vec++; if (cmpl_err_o !== 1'b0) begin n_err++; $display("FAIL cmpl_err_early got %b exp 0", cmpl_err_o); end
    tick();
    set_idle();
    #1;
    n_vec++; if (cmpl_err_o !== 1'b1) begin n_err++; $display("FAIL cmpl_err_pulse got %b exp 1", cmpl_err_o); end
    tick();
    #1;
    n_vec++; if (cmpl_err_o !== 1'b0) begin n_err++; $display("FAIL cmpl_err_width got %b exp 0", cmpl_err_o); end
  endtask

  task automatic test_waw();
    do_reset();
    drive_write(3, 4, 1'b0);
    tick();
    drive_write(3, 1, 1'b0);
    #1;
    n_vec++; if (waw_stall_o !== 1'b1) begin n_err++; $display("FAIL waw_stall got %b exp 1", waw_stall_o); end
    n_vec++; if (raw_stall_o !== 1'b0) begin n_err++; $display("FAIL waw_raw got %b exp 0", raw_stall_o); end
    n_vec++; if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL waw_ready got %b exp 0", issue_ready_o); end
    issue_lat_i = LAT_W'(4);
    #1;
    n_vec++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL waw_reload_ready got %b exp 1", issue_ready_o); end
    tick();
    set_idle();
    for (int k = 2; k <= 6; k++) begin
      #1;
      n_vec++; if (busy_o[3] !== (k <= 5)) begin n_err++; $display("FAIL waw_reload_busy c%0d got %b exp %b", k, busy_o[3], (k <= 5)); end
      tick();
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive_write(0, 4, 1'b0);
    #1;
    n_vec++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL x0_wr_ready got %b exp 1", issue_ready_o); end
    tick();
    set_idle();
    issue_valid_i  = 1'b1;
    issue_rs1_rd_i = 1'b1;
    issue_rs2_rd_i = 1'b1;
    #1;
    n_vec++; if (busy_o !== '0) begin n_err++; $display("FAIL x0_busy got %h exp 0", busy_o); end
    n_vec++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL x0_rd_ready got %b exp 1", issue_ready_o); end
    tick();
    set_idle();
  endtask

  task automatic test_flush();
    logic [NUM_REGS-1:0] eb;
    do_reset();
    drive_write(1, 4, 1'b0); tick();
    drive_write(2, 4, 1'b0); tick();
    drive_write(9, 2, 1'b1); tick();
    drive_write(10, 2, 1'b0);
    flush_i = 1'b1;
    #1;
    eb = '0; eb[1] = 1'b1; eb[2] = 1'b1; eb[9] = 1'b1;
    n_vec++; if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b exp 0", issue_ready_o); end
    n_vec++; if (busy_o !== eb) begin n_err++; $display("FAIL flush_pre_busy got %h exp %h", busy_o, eb); end
    tick();
    set_idle();
    #1;
    eb = '0; eb[9] = 1'b1;
    n_vec++; if (busy_o !== eb) begin n_err++; $display("FAIL flush_post_busy got %h exp %h", busy_o, eb); end
    cmpl_valid_i = 1'b1;
    cmpl_rd_i    = 5'd9;
    tick();
    set_idle();
    #1;
    n_vec++; if (busy_o !== '0) begin n_err++; $display("FAIL flush_cmpl_busy got %h exp 0", busy_o); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive_write(4, 4, 1'b0); tick();
    drive_write(6, 1, 1'b1); tick();
    set_idle();
    issue_valid_i  = 1'b1;
    issue_rs1_i    = 5'd4;
    issue_rs1_rd_i = 1'b1;
    #1;
    n_vec++; if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL midrst_pre_ready got %b exp 0", issue_ready_o); end
    reset_n_i = 1'b0;
    model_reset();
    #1;
    n_vec++; if (busy_o !== '0) begin n_err++; $display("FAIL midrst_busy got %h exp 0", busy_o); end
    n_vec++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b exp 1", issue_ready_o); end
    #1;
    reset_n_i = 1'b1;
    #1;
    n_vec++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_post_ready got %b exp 1", issue_ready_o); end
    tick();
    set_idle();
  endtask

  task automatic test_random();
    logic [NUM_REGS-1:0] eb;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      issue_valid_i  = ($urandom_range(0, 3) != 0);
      issue_rs1_i    = REG_ADDR_W'($urandom_range(0, 7));
      issue_rs2_i    = REG_ADDR_W'($urandom_range(0, 7));
      issue_rs1_rd_i = $urandom_range(0, 1) == 1;
      issue_rs2_rd_i = $urandom_range(0, 1) == 1;
      issue_rd_i     = REG_ADDR_W'($urandom_range(0, 7));
      issue_we_i     = ($urandom_range(0, 3) != 0);
      issue_lat_i    = LAT_W'($urandom_range(0, MAX_LAT));
      issue_var_i    = ($urandom_range(0, 5) == 0);
      cmpl_valid_i   = ($urandom_range(0, 3) == 0);
      cmpl_rd_i      = REG_ADDR_W'($urandom_range(0, 7));
      flush_i        = ($urandom_range(0, 19) == 0);
      #1;
      eb = m_busy_vec();
      n_vec++; if (issue_ready_o !== m_ready()) begin n_err++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, issue_ready_o, m_ready()); end
      n_vec++; if (raw_stall_o !== (issue_valid_i && m_raw())) begin n_err++; $display("FAIL rnd_raw cyc=%0d got %b exp %b", cyc, raw_stall_o, issue_valid_i && m_raw()); end
      n_vec++; if (waw_stall_o !== (issue_valid_i && m_waw())) begin n_err++; $display("FAIL rnd_waw cyc=%0d got %b exp %b", cyc, waw_stall_o, issue_valid_i && m_waw()); end
      n_vec++; if (fwd_rs1_o !== m_fwd(issue_rs1_rd_i, int'(issue_rs1_i))) begin n_err++; $display("FAIL rnd_fwd1 cyc=%0d got %b", cyc, fwd_rs1_o); end
      n_vec++; if (fwd_rs2_o !== m_fwd(issue_rs2_rd_i, int'(issue_rs2_i))) begin n_err++; $display("FAIL rnd_fwd2 cyc=%0d got %b", cyc, fwd_rs2_o); end
      n_vec++; if (busy_o !== eb) begin n_err++; $display("FAIL rnd_busy cyc=%0d got %h exp %h", cyc, busy_o, eb); end
      n_vec++; if (cmpl_err_o !== err_exp) begin n_err++; $display("FAIL rnd_cmpl_err cyc=%0d got %b exp %b", cyc, cmpl_err_o, err_exp); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    set_idle();
    reset_n_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    test_reset();
    test_fixed_raw();
    test_var_cmpl();
    test_waw();
    test_x0();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
